// File: rtl/rv_g_pkg.sv
// Shared register-file definitions for the rv_g core: register address width
// and the integer/float split of the 64-entry destination address space.
package rv_g_pkg;

    localparam int unsigned RegAddrW = 6;
    localparam int unsigned FpSelBit = 5;

    typedef logic [RegAddrW-1:0] reg_addr_t;

    typedef enum logic {
        REG_INT = 1'b0,
        REG_FP  = 1'b1
    } reg_file_e;

    // Addresses 0-31 select the integer file, 32-63 the float file.
    function automatic reg_file_e addr_file(input reg_addr_t addr);
        return reg_file_e'(addr[FpSelBit]);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
// Produces a one-hot grant and the matching binary index.
module rr_arbiter #(
    parameter  int unsigned N    = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [IdxW-1:0] grant_idx
);

    logic found;

    always_comb begin : search
        int unsigned     pos;
        logic [IdxW-1:0] cand;
        // NOTE: combinational logic uses blocking assignments with every output
        // defaulted first, so no path through the block can infer a latch.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            cand = IdxW'(pos);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rv_g_wb_arbiter.sv
// Write-back arbiter: one skid entry per result source, round-robin selection
// and a registered register-file write port with int/float width formatting.
module rv_g_wb_arbiter
    import rv_g_pkg::*;
#(
    parameter  int unsigned XLEN    = 64,
    parameter  int unsigned FLEN    = 64,
    parameter  int unsigned NUM_SRC = 4,
    localparam int unsigned MaxLen  = (XLEN > FLEN) ? XLEN : FLEN
) (
    input  logic                              clk_i,
    input  logic                              arst_ni,
    input  logic [NUM_SRC-1:0]                src_valid_i,
    output logic [NUM_SRC-1:0]                src_ready_o,
    input  logic [NUM_SRC-1:0][RegAddrW-1:0]  src_addr_i,
    input  logic [NUM_SRC-1:0][MaxLen-1:0]    src_data_i,
    output logic [RegAddrW-1:0]               wr_addr_o,
    output logic [MaxLen-1:0]                 wr_data_o,
    output logic                              wr_en_o,
    output logic                              busy_o
);

    localparam int unsigned       IdxW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [MaxLen-1:0] IntKeep = MaxLen'({XLEN{1'b1}});
    localparam logic [MaxLen-1:0] NanBox  = ~MaxLen'({FLEN{1'b1}});

    logic [NUM_SRC-1:0] buf_valid_q;
    reg_addr_t          buf_addr_q [NUM_SRC];
    logic [MaxLen-1:0]  buf_data_q [NUM_SRC];

    logic [NUM_SRC-1:0] grant;
    logic [IdxW-1:0]    grant_idx;
    logic [IdxW-1:0]    ptr_q;
    logic [NUM_SRC-1:0] accept;
    logic               any_grant;

    reg_addr_t          sel_addr;
    logic [MaxLen-1:0]  sel_data;

    logic               wr_en_q;
    reg_addr_t          wr_addr_q;
    logic [MaxLen-1:0]  wr_data_q;

    // Integer results are zero-extended, float results NaN-boxed above FLEN.
    function automatic logic [MaxLen-1:0] wb_format(input reg_addr_t addr,
                                                    input logic [MaxLen-1:0] data);
        if (addr_file(addr) == REG_INT) begin
            return data & IntKeep;
        end
        return data | NanBox;
    endfunction

    rr_arbiter #(
        .N (NUM_SRC)
    ) u_rr_arbiter (
        .req       (buf_valid_q),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // A granted entry frees its slot this cycle, so the source may refill it on
    // the same edge and keep one write per cycle flowing.
    assign src_ready_o = ~buf_valid_q | grant;
    assign accept      = src_valid_i & src_ready_o;
    assign any_grant   = |grant;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            buf_valid_q <= '0;
        end else begin
            buf_valid_q <= accept | (buf_valid_q & ~grant);
        end
    end

    // NOTE: the buffer payload is deliberately left unreset; buf_valid_q gates
    // every use of it, and dropping the reset keeps these plain data flops.
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (accept[i]) begin
                buf_addr_q[i] <= src_addr_i[i];
                buf_data_q[i] <= src_data_i[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            ptr_q <= '0;
        end else if (any_grant) begin
            if (grant_idx == IdxW'(NUM_SRC - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= grant_idx + 1'b1;
            end
        end
    end

    assign sel_addr = buf_addr_q[grant_idx];
    assign sel_data = buf_data_q[grant_idx];

    // Address and data hold their last value between writes; only the strobe pulses.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= any_grant;
            if (any_grant) begin
                wr_addr_q <= sel_addr;
                wr_data_q <= wb_format(sel_addr, sel_data);
            end
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign busy_o    = (|buf_valid_q) | wr_en_q;

endmodule
